// File: rtl/bus_pkg.sv
// Shared types and constants for the two-initiator split-capable bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } arb_state_t;

    typedef enum logic {
        INIT1 = 1'b0,
        INIT2 = 1'b1
    } init_id_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned HOLD_W          = 16;

    function automatic arb_state_t owner_state(input init_id_t id);
        return (id == INIT2) ? OWN2 : OWN1;
    endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Grant hold counter: cleared on every new grant, counts owned cycles and
// flags the owned cycle whose increment reaches TIMEOUT_CYCLES.
module arb_hold_timer
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam logic [HOLD_W-1:0] LAST_CNT = HOLD_W'(TIMEOUT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (clear_i) begin
            hold_d = '0;
        end else if (count_i) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // The first owned cycle sees zero, so TIMEOUT_CYCLES owned cycles end on LAST_CNT.
    assign expire_o = count_i && (hold_q == LAST_CNT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-initiator bus arbiter with split/resume and forced revocation on hold timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin on ties; default is fixed priority (1 over 2).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic       target_split,
    input  logic       split_release,
    output logic       grant1,
    output logic       grant2,
    output logic       msel,
    output logic       split_pending,
    output logic       timeout,
    output logic [1:0] dbg_state_o
);

    // req/grant contract: an initiator raises req and holds it for the whole
    // transaction; grant rises the cycle after req is sampled in IDLE and falls
    // the cycle after req drops, a split is taken, or the hold timer expires.

    arb_state_t state_q, state_d;
    logic       split_pending_q, split_pending_d;
    init_id_t   split_id_q, split_id_d;
    logic       resume_q, resume_d;
    logic       msel_q, msel_d;
    logic       timeout_q, timeout_d;
    logic       new_grant;
    init_id_t   win;
    logic       elig1, elig2;
    logic       owner_req;
    init_id_t   owner_id;
    logic       expire;
`ifdef ARB_ROUND_ROBIN_EN
    init_id_t   last_q, last_d;
`endif

    // A parked initiator stays invisible to arbitration until its resume grant.
    assign elig1     = req1 && !(split_pending_q && (split_id_q == INIT1));
    assign elig2     = req2 && !(split_pending_q && (split_id_q == INIT2));
    assign owner_req = (state_q == OWN2) ? req2 : req1;
    assign owner_id  = (state_q == OWN2) ? INIT2 : INIT1;

    arb_hold_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (new_grant),
        .count_i (state_q != IDLE),
        .expire_o(expire)
    );

    always_comb begin
        state_d         = state_q;
        split_pending_d = split_pending_q;
        split_id_d      = split_id_q;
        resume_d        = resume_q;
        msel_d          = msel_q;
        timeout_d       = 1'b0;
        new_grant       = 1'b0;
        win             = INIT1;
`ifdef ARB_ROUND_ROBIN_EN
        last_d          = last_q;
`endif

        if (split_release && split_pending_q) begin
            resume_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (resume_q) begin
                    new_grant       = 1'b1;
                    win             = split_id_q;
                    split_pending_d = 1'b0;
                    resume_d        = 1'b0;
                end else if (elig1 && elig2) begin
                    new_grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    win       = (last_q == INIT1) ? INIT2 : INIT1;
`else
                    win       = INIT1;
`endif
                end else if (elig1) begin
                    new_grant = 1'b1;
                    win       = INIT1;
                end else if (elig2) begin
                    new_grant = 1'b1;
                    win       = INIT2;
                end

                if (new_grant) begin
                    state_d = owner_state(win);
                    msel_d  = (win == INIT2);
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = win;
`endif
                end
            end
            OWN1, OWN2: begin
                // Release beats split beats timeout when they coincide.
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (target_split && !split_pending_q) begin
                    state_d         = IDLE;
                    split_pending_d = 1'b1;
                    split_id_d      = owner_id;
                end else if (expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            split_pending_q <= 1'b0;
            split_id_q      <= INIT1;
            resume_q        <= 1'b0;
            msel_q          <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            split_pending_q <= split_pending_d;
            split_id_q      <= split_id_d;
            resume_q        <= resume_d;
            msel_q          <= msel_d;
            timeout_q       <= timeout_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer starts at initiator 2 so initiator 1 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= INIT2;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign grant1        = (state_q == OWN1);
    assign grant2        = (state_q == OWN2);
    assign msel          = msel_q;
    assign split_pending = split_pending_q;
    assign timeout       = timeout_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int unsigned TO_MAIN  = 255;
    localparam int unsigned TO_SHORT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req1, req2, target_split, split_release;
    logic       grant1, grant2, msel, split_pending, timeout;
    logic [1:0] dbg_state;
    logic       t_grant1, t_grant2, t_msel, t_split_pending, t_timeout;
    logic [1:0] t_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_q[$];

    // Reference model: owner/parked as initiator numbers (0 = none), held = owned cycles so far.
    int m_owner, m_parked, m_last, m_held;
    bit m_resume, m_msel;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TO_MAIN)) dut (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .target_split(target_split), .split_release(split_release),
        .grant1(grant1), .grant2(grant2), .msel(msel),
        .split_pending(split_pending), .timeout(timeout), .dbg_state_o(dbg_state)
    );

    bus_arbiter #(.TIMEOUT_CYCLES(TO_SHORT)) dut_to (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2),
        .target_split(target_split), .split_release(split_release),
        .grant1(t_grant1), .grant2(t_grant2), .msel(t_msel),
        .split_pending(t_split_pending), .timeout(t_timeout), .dbg_state_o(t_dbg_state)
    );

    function automatic logic [4:0] obs();
        return {grant1, grant2, msel, split_pending, timeout};
    endfunction

    function automatic logic [4:0] obs_to();
        return {t_grant1, t_grant2, t_msel, t_split_pending, t_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b, input logic s, input logic r);
        req1 = a; req2 = b; target_split = s; split_release = r;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_owner = 0; m_parked = 0; m_last = 2; m_held = 0;
        m_resume = 1'b0; m_msel = 1'b0;
    endtask

    task automatic model_step(input logic r1, input logic r2, input logic ts, input logic sr);
        int w, owner_n, parked_n, held_n;
        bit resume_n, to_n, own_req, e1, e2;
        owner_n = m_owner; parked_n = m_parked; held_n = m_held;
        resume_n = m_resume; to_n = 1'b0; w = 0;
        if (sr && m_parked != 0) resume_n = 1'b1;
        if (m_owner == 0) begin
            if (m_resume) begin
                w = m_parked; parked_n = 0; resume_n = 1'b0;
            end else begin
                e1 = r1 && (m_parked != 1);
                e2 = r2 && (m_parked != 2);
`ifdef ARB_ROUND_ROBIN_EN
                if (e1 && e2) w = (m_last == 1) ? 2 : 1;
`else
                if (e1 && e2) w = 1;
`endif
                else if (e1) w = 1;
                else if (e2) w = 2;
            end
            if (w != 0) begin
                owner_n = w; held_n = 1; m_last = w; m_msel = (w == 2);
            end
        end else begin
            own_req = (m_owner == 1) ? r1 : r2;
            if (!own_req) owner_n = 0;
            else if (ts && m_parked == 0) begin
                parked_n = m_owner; owner_n = 0;
            end else if (m_held == int'(TO_MAIN)) begin
                owner_n = 0; to_n = 1'b1;
            end else held_n = m_held + 1;
        end
        m_owner = owner_n; m_parked = parked_n; m_held = held_n; m_resume = resume_n;
        exp_q.push_back({owner_n == 1, owner_n == 2, m_msel, parked_n != 0, to_n});
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        if ({obs(), obs_to()} !== 10'b0) begin
            n_bad++; $display("FAIL reset_async got=%b/%b exp=00000/00000", obs(), obs_to());
        end
        n_cmp++;
        if (dbg_state !== 2'(IDLE)) begin
            n_bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, 2'(IDLE));
        end
        n_cmp++;
        tick();
        rst = 1'b0;
        drive(1, 1, 0, 0);
        tick();
        if (obs() !== 5'b10000) begin
            n_bad++; $display("FAIL reset_first_grant got=%b exp=10000", obs());
        end
        n_cmp++;
        #2 rst = 1'b1;
        #1;
        if ({obs(), obs_to()} !== 10'b0) begin
            n_bad++; $display("FAIL reset_owned got=%b/%b exp=00000/00000", obs(), obs_to());
        end
        n_cmp++;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 1, 0, 0);
        tick();
        if (obs() !== 5'b10000) begin
            n_bad++; $display("FAIL prio_c1 got=%b exp=10000", obs());
        end
        n_cmp++;
        repeat (4) tick();
        if (obs() !== 5'b10000) begin
            n_bad++; $display("FAIL prio_c5 got=%b exp=10000", obs());
        end
        n_cmp++;
        drive(0, 1, 0, 0);
        tick();
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL prio_turnaround got=%b exp=00000", obs());
        end
        n_cmp++;
        tick();
        if (obs() !== 5'b01100) begin
            n_bad++; $display("FAIL prio_grant2 got=%b exp=01100", obs());
        end
        n_cmp++;
        drive(0, 0, 0, 0);
        tick();
        if (obs() !== 5'b00100) begin
            n_bad++; $display("FAIL prio_msel_hold got=%b exp=00100", obs());
        end
        n_cmp++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(1, 1, 0, 0);
            tick();
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (r == 1) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b10;
`endif
            if ({grant1, grant2} !== exp_g) begin
                n_bad++; $display("FAIL rr_round%0d got=%b exp=%b", r, {grant1, grant2}, exp_g);
            end
            n_cmp++;
            drive(0, 0, 0, 0);
            tick();
            if ({grant1, grant2} !== 2'b00) begin
                n_bad++; $display("FAIL rr_idle%0d got=%b exp=00", r, {grant1, grant2});
            end
            n_cmp++;
        end
    endtask

    task automatic test_split();
        do_reset();
        drive(1, 1, 0, 0);
        tick();
        if (obs() !== 5'b10000) begin
            n_bad++; $display("FAIL split_c1 got=%b exp=10000", obs());
        end
        n_cmp++;
        tick(); tick();
        drive(1, 1, 1, 0);
        tick();
        drive(1, 1, 0, 0);
        if (obs() !== 5'b00010) begin
            n_bad++; $display("FAIL split_park got=%b exp=00010", obs());
        end
        n_cmp++;
        tick();
        if (obs() !== 5'b01110) begin
            n_bad++; $display("FAIL split_other got=%b exp=01110", obs());
        end
        n_cmp++;
        tick(); tick(); tick();
        drive(1, 1, 0, 1);
        tick();
        drive(1, 1, 0, 0);
        if (obs() !== 5'b01110) begin
            n_bad++; $display("FAIL split_release_wait got=%b exp=01110", obs());
        end
        n_cmp++;
        tick();
        drive(1, 0, 0, 0);
        tick();
        if (obs() !== 5'b00110) begin
            n_bad++; $display("FAIL split_idle got=%b exp=00110", obs());
        end
        n_cmp++;
        drive(1, 1, 0, 0);
        tick();
        if (obs() !== 5'b10000) begin
            n_bad++; $display("FAIL split_resume got=%b exp=10000", obs());
        end
        n_cmp++;
    endtask

    task automatic test_timeout();
        logic [1:0] exp_t;
        do_reset();
        drive(0, 1, 0, 0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_t = {(c <= 4 || c >= 6), (c == 5)};
            if ({t_grant2, t_timeout} !== exp_t) begin
                n_bad++; $display("FAIL timeout_c%0d grant2/timeout got=%b exp=%b", c, {t_grant2, t_timeout}, exp_t);
            end
            n_cmp++;
            if ({grant2, timeout} !== 2'b10) begin
                n_bad++; $display("FAIL timeout_long_c%0d got=%b exp=10", c, {grant2, timeout});
            end
            n_cmp++;
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_spurious();
        do_reset();
        drive(0, 0, 1, 1);
        tick();
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL spur_idle got=%b exp=00000", obs());
        end
        n_cmp++;
        drive(0, 1, 0, 0);
        tick();
        if (obs() !== 5'b01100) begin
            n_bad++; $display("FAIL spur_grant got=%b exp=01100", obs());
        end
        n_cmp++;
        drive(0, 0, 1, 0);
        tick();
        if (obs() !== 5'b00100) begin
            n_bad++; $display("FAIL spur_drop_split got=%b exp=00100", obs());
        end
        n_cmp++;
        drive(0, 0, 1, 1);
        tick();
        if (obs() !== 5'b00100) begin
            n_bad++; $display("FAIL spur_release got=%b exp=00100", obs());
        end
        n_cmp++;
        drive(0, 1, 0, 0);
        tick();
        if (obs() !== 5'b01100) begin
            n_bad++; $display("FAIL spur_not_parked got=%b exp=01100", obs());
        end
        n_cmp++;
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 1, 0, 0);
        tick();
        drive(1, 1, 1, 0);
        tick();
        drive(1, 1, 0, 0);
        tick();
        if (obs() !== 5'b01110) begin
            n_bad++; $display("FAIL rmid_setup got=%b exp=01110", obs());
        end
        n_cmp++;
        #2 rst = 1'b1;
        #1;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL rmid_async got=%b exp=00000", obs());
        end
        n_cmp++;
        tick();
        rst = 1'b0;
        if (obs() !== 5'b00000) begin
            n_bad++; $display("FAIL rmid_released got=%b exp=00000", obs());
        end
        n_cmp++;
        tick();
        if (obs() !== 5'b10000) begin
            n_bad++; $display("FAIL rmid_regrant got=%b exp=10000", obs());
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic r1, r2, ts, sr;
        logic [4:0] exp_v;
        do_reset();
        model_reset();
        exp_q.delete();
        r1 = 1'b0; r2 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) r1 = ~r1;
            if ($urandom_range(0, 5) == 0) r2 = ~r2;
            ts = ($urandom_range(0, 7) == 0);
            sr = ($urandom_range(0, 5) == 0);
            drive(r1, r2, ts, sr);
            model_step(r1, r2, ts, sr);
            tick();
            exp_v = exp_q.pop_front();
            if (obs() !== exp_v) begin
                n_bad++; $display("FAIL random_c%0d got=%b exp=%b", i, obs(), exp_v);
            end
            n_cmp++;
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        test_reset();
        test_priority();
        test_round_robin();
        test_split();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, maximum cycles one grant is held before forced revocation (range 2..65535).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req1  input  1  initiator 1 bus request, held for whole transaction.
REQ-005 req2  input  1  initiator 2 bus request, held for whole transaction.
REQ-006 target_split  input  1  target splits the current transaction (1-cycle pulse).
REQ-007 split_release  input  1  split target ready to resume (1-cycle pulse).
REQ-008 grant1  output  1  bus granted to initiator 1.
REQ-009 grant2  output  1  bus granted to initiator 2.
REQ-010 msel  output  1  bus mux select, 0 = initiator 1, 1 = initiator 2.
REQ-011 split_pending  output  1  an initiator is parked on a split.
REQ-012 timeout  output  1  1-cycle pulse on forced revocation.

Function
REQ-013 FSM states SHALL be IDLE, OWN1 and OWN2; grant1 = (state==OWN1) and grant2 = (state==OWN2), both registered, never both high.
REQ-014 Eligible requester: req high and not parked.
REQ-015 In IDLE the arbiter SHALL grant one eligible requester, with the grant visible the cycle after req is sampled (1-cycle latency).
REQ-016 Default policy: fixed priority, initiator 1 over initiator 2.
REQ-017 Release: owner req low -> grant low next cycle, state IDLE; the next grant comes no earlier than the following cycle (1 idle turnaround cycle).
REQ-018 target_split while owned: grant low next cycle, split_pending=1, split_id=owner, state IDLE; the parked initiator's req is ignored until resume.
REQ-019 target_split in IDLE, or while split_pending=1: ignored; grant unchanged.
REQ-020 split_release with split_pending=1: sets resume flag; on the next IDLE cycle the parked initiator SHALL be granted ahead of any requester, then split_pending and resume SHALL clear.
REQ-021 split_release with split_pending=0: ignored.
REQ-022 Owner req drop and target_split in the same cycle: treated as release; no parking.
REQ-023 Hold counter: 16 bits, cleared on each new grant, incremented each owned cycle; on reaching TIMEOUT_CYCLES the grant SHALL drop next cycle, timeout pulses 1 cycle, state IDLE.
REQ-024 msel SHALL update with each new grant and hold its last value while IDLE.

Reset
REQ-025 rst high SHALL asynchronously force state IDLE, grant1=grant2=0, msel=0, split_pending=0, resume=0, timeout=0, hold counter=0 and round-robin pointer=initiator 2 (so initiator 1 wins first).
REQ-026 Reset mid-transaction or mid-split SHALL discard the parked initiator; the first grant after rst falls follows REQ-015.

Configuration
REQ-027 ARB_ROUND_ROBIN_EN defined: on simultaneous eligible requests, grant the initiator not granted last; pointer updates on every new grant, including split resume.
REQ-028 ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-016; no pointer register.

Structure
REQ-029 Shared package bus_pkg SHALL hold the arb_state_t enum (IDLE, OWN1, OWN2), the initiator-id type and the default TIMEOUT constant.
REQ-030 Sub-module arb_hold_timer SHALL hold the hold counter and timeout compare; the FSM stays in bus_arbiter.

Verification
REQ-031 req1=req2=1 from IDLE at cycle 0 -> grant1=1 at cycle 1; req1 low at cycle 5 -> grant1=0 at 6, grant2=1 at 7, msel=1.
REQ-032 ARB_ROUND_ROBIN_EN: three back-to-back simultaneous req1/req2 rounds -> grant order 1,2,1.
REQ-033 Owner 1, target_split at cycle 3 -> grant1=0 and split_pending=1 at 4; req2 granted at 5; split_release at 8; req2 drop at 10 -> grant1=1 at 12 ahead of req2, split_pending=0.
REQ-034 TIMEOUT_CYCLES=4, req2 held -> grant2 high 4 cycles, then drops with a 1-cycle timeout pulse; regranted after 1 idle cycle.
REQ-035 Spurious split_release with no pending and target_split in IDLE -> no output change; req drop with target_split in the same cycle -> split_pending stays 0.
REQ-036 rst pulse during OWN2 with split_pending=1 -> all outputs 0 immediately; after release, req1 granted 1 cycle later.
